// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads sources with write-to-read bypass, tracks pending writes
// per register, stalls on RAW/WAW hazards and holds operands in a one-entry register.
module operand_fetch #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  output logic [ADDR_W-1:0] rs1_addr,
  output logic [ADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rs1_rdata,
  input  logic [DATA_W-1:0] rs2_rdata,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rdaddr,
  output logic [DATA_W-1:0] rd_wdata,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_opcode,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_rd_we,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [NumRegs-1:0] pend_q, pend_d;
  logic               ex_valid_q;
  logic [OP_W-1:0]    ex_opcode_q;
  logic [ADDR_W-1:0]  ex_rd_q;
  logic               ex_rd_we_q;
  logic [DATA_W-1:0]  ex_rs1_q, ex_rs2_q;

  logic              wb_hit1, wb_hit2, wb_hit_rd;
  logic              raw1, raw2, waw, hazard, accept;
  logic [DATA_W-1:0] src1, src2;

  assign rs1_addr = id_rs1;
  assign rs2_addr = id_rs2;
  assign rd_en    = wb_en;
  assign rdaddr   = wb_addr;
  assign rd_wdata = wb_data;

  assign wb_hit1   = wb_en && (wb_addr == id_rs1);
  assign wb_hit2   = wb_en && (wb_addr == id_rs2);
  assign wb_hit_rd = wb_en && (wb_addr == id_rd);

  // Register 0 reads zero even when a writeback targets it.
  always_comb begin
    src1 = rs1_rdata;
    if (id_rs1 == '0)  src1 = '0;
    else if (wb_hit1)  src1 = wb_data;
    src2 = rs2_rdata;
    if (id_rs2 == '0)  src2 = '0;
    else if (wb_hit2)  src2 = wb_data;
  end

  assign raw1     = (id_rs1 != '0) && pend_q[id_rs1] && !wb_hit1;
  assign raw2     = (id_rs2 != '0) && pend_q[id_rs2] && !wb_hit2;
  assign waw      = id_rd_we && (id_rd != '0) && pend_q[id_rd] && !wb_hit_rd;
  assign hazard   = raw1 || raw2 || waw;
  assign id_ready = (!ex_valid_q || ex_ready) && !hazard;
  assign accept   = id_valid && id_ready;

  // A new producer on the same cycle as the old one's writeback keeps the entry set.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned r = 1; r < NumRegs; r++) begin
      if (accept && id_rd_we && (id_rd == ADDR_W'(r))) begin
        pend_d[r] = 1'b1;
      end else if (wb_en && (wb_addr == ADDR_W'(r))) begin
        pend_d[r] = 1'b0;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= '0;
      ex_rd_q     <= '0;
      ex_rd_we_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
    end else begin
      pend_q <= pend_d;
      if (accept) begin
        ex_valid_q  <= 1'b1;
        ex_opcode_q <= id_opcode;
        ex_rd_q     <= id_rd;
        ex_rd_we_q  <= id_rd_we;
        ex_rs1_q    <= src1;
        ex_rs2_q    <= src2;
      end else if (ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rd_we    = ex_rd_we_q;
  assign ex_rs1_data = ex_rs1_q;
  assign ex_rs2_data = ex_rs2_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard/bypass scenarios then random traffic,
// checked against a set-of-outstanding-writes model and a bench-owned register file.
module tb_operand_fetch;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned OP_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_ready, id_rd_we;
  logic [OP_W-1:0]   id_opcode;
  logic [ADDR_W-1:0] id_rd, id_rs1, id_rs2, rs1_addr, rs2_addr;
  logic [DATA_W-1:0] rs1_rdata, rs2_rdata;
  logic              wb_en, rd_en;
  logic [ADDR_W-1:0] wb_addr, rdaddr;
  logic [DATA_W-1:0] wb_data, rd_wdata;
  logic              ex_valid, ex_ready, ex_rd_we;
  logic [OP_W-1:0]   ex_opcode;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_rs1_data, ex_rs2_data;

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .rd_en(rd_en), .rdaddr(rdaddr), .rd_wdata(rd_wdata),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data)
  );

  // Bench-owned register file; entry 0 holds junk so the stage must zero it itself.
  logic [DATA_W-1:0] regs [16];
  assign rs1_rdata = regs[rs1_addr];
  assign rs2_rdata = regs[rs2_addr];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: outstanding destinations and the expected execute-side register.
  bit                outstanding [16];
  bit                m_valid;
  logic [OP_W-1:0]   m_op;
  logic [ADDR_W-1:0] m_rd;
  bit                m_we;
  logic [DATA_W-1:0] m_d1, m_d2;

  function automatic bit delivering(input logic [ADDR_W-1:0] r);
    return wb_en && wb_addr == r;
  endfunction

  function automatic bit blocked(input logic [ADDR_W-1:0] r);
    return r != 0 && outstanding[r] && !delivering(r);
  endfunction

  function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] r);
    if (r == 0) return '0;
    if (delivering(r)) return wb_data;
    return regs[r];
  endfunction

  task automatic model_reset();
    foreach (outstanding[i]) outstanding[i] = 0;
    m_valid = 0; m_op = '0; m_rd = '0; m_we = 0; m_d1 = '0; m_d2 = '0;
  endtask

  // One clock: inputs already driven; check combinational outputs, advance, check ex_*.
  task automatic step();
    bit exp_ready, take;
    logic [DATA_W-1:0] s1, s2;
    #1;
    exp_ready = (!m_valid || ex_ready) && !blocked(id_rs1) && !blocked(id_rs2)
                && !(id_rd_we && blocked(id_rd));
    s1 = operand(id_rs1);
    s2 = operand(id_rs2);
    check("rs1_addr", rs1_addr, id_rs1);
    check("rs2_addr", rs2_addr, id_rs2);
    check("wb_pass", {rd_en, rdaddr, rd_wdata}, {wb_en, wb_addr, wb_data});
    if (rst_n) check("id_ready", id_ready, exp_ready);
    take = rst_n && id_valid && exp_ready;
    @(posedge clk);
    if (wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (wb_en) outstanding[wb_addr] = 0;
      if (take && id_rd_we && id_rd != 0) outstanding[id_rd] = 1;
      if (take) begin
        m_valid = 1; m_op = id_opcode; m_rd = id_rd; m_we = id_rd_we; m_d1 = s1; m_d2 = s2;
      end else if (ex_ready) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    check("ex_valid", ex_valid, m_valid);
    check("ex_ctl", {ex_opcode, ex_rd, ex_rd_we}, {m_op, m_rd, m_we});
    check("ex_rs1_data", ex_rs1_data, m_d1);
    check("ex_rs2_data", ex_rs2_data, m_d2);
  endtask

  task automatic idle();
    id_valid = 0; id_opcode = '0; id_rd = '0; id_rd_we = 0; id_rs1 = '0; id_rs2 = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; ex_ready = 1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] rd, input bit we,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    id_valid = 1; id_opcode = OP_W'($urandom); id_rd = rd; id_rd_we = we;
    id_rs1 = r1; id_rs2 = r2;
  endtask

  task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  int k;
  logic [ADDR_W-1:0] cand [$];

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = DATA_W'($urandom);
    regs[0] = 16'hDEAD;
    regs[3] = 16'h1234;
    regs[5] = 16'h00AA;
    model_reset();
    idle();
    rst_n = 0;
    @(negedge clk);

    // Reset then a simple issue.
    step(); step();
    rst_n = 1;
    #1 check("reset_ready", id_ready, 1);
    issue(0, 0, 3, 0); step();
    check("rs1_reg3", ex_rs1_data, 16'h1234);

    // Same-cycle bypass, and writeback to register 0 stays invisible.
    idle(); issue(0, 0, 5, 0); wb(5, 16'h5555); step();
    check("bypass", ex_rs1_data, 16'h5555);
    idle(); issue(0, 0, 0, 0); wb(0, 16'hFFFF); step();
    check("r0_zero", ex_rs2_data, 16'h0000);

    // RAW stall released by writeback in the stall cycle.
    idle(); issue(7, 1, 0, 0); step();
    idle(); issue(0, 0, 7, 0); step();
    check("raw_stall", id_ready, 0);
    wb(7, 16'hBEEF); step();
    check("raw_bypass", ex_rs1_data, 16'hBEEF);
    idle(); issue(0, 0, 7, 0); step();
    check("raw_cleared", ex_valid, 1);

    // WAW stall, then accept on the collision cycle; entry stays pending.
    idle(); issue(2, 1, 0, 0); step();
    idle(); issue(2, 1, 0, 0); step();
    wb(2, 16'h2222); step();
    idle(); issue(0, 0, 2, 0); step();
    check("waw_still_pend", id_ready, 0);
    idle(); wb(2, 16'h3333); step();

    // Backpressure then back-to-back transfer.
    idle(); issue(1, 0, 3, 5); step();
    ex_ready = 0; issue(0, 0, 5, 3);
    for (int i = 0; i < 3; i++) step();
    check("bp_hold", ex_rs1_data, 16'h1234);
    ex_ready = 1; step();
    check("b2b_valid", ex_valid, 1);

    // Reset mid-operation clears outstanding writes.
    idle(); issue(4, 1, 0, 0); step();
    idle(); rst_n = 0; step();
    rst_n = 1; issue(0, 0, 4, 0); step();
    check("post_reset_issue", ex_valid, 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_n = ($urandom_range(0, 199) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        issue(ADDR_W'($urandom), $urandom_range(0, 1) == 1, ADDR_W'($urandom),
              ADDR_W'($urandom));
      cand.delete();
      for (int r = 1; r < 16; r++) if (outstanding[r]) cand.push_back(ADDR_W'(r));
      k = $urandom_range(0, 9);
      if (cand.size() > 0 && k < 5)
        wb(cand[$urandom_range(0, cand.size() - 1)], DATA_W'($urandom));
      else if (k == 9)
        wb(ADDR_W'($urandom), DATA_W'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue/operand-fetch stage between instruction decode and execute.
- Takes decoded instructions over a valid/ready handshake and drives both register-file read addresses.
- Merges the two read ports with a write-to-read bypass and registers the operands into a one-entry pipeline register facing execute.
- Keeps a per-register pending-write scoreboard and stalls on RAW/WAW hazards; passes the writeback port through to the register file.

Parameters:
- DATA_W, 16, operand/result width.
- ADDR_W, 4, register address width (2^ADDR_W registers; register 0 hardwired zero).
- OP_W, 4, opcode width carried to execute.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_opcode  in  OP_W  opcode.
- id_rd  in  ADDR_W  destination register.
- id_rd_we  in  1  instruction writes rd.
- id_rs1  in  ADDR_W  source 1 address.
- id_rs2  in  ADDR_W  source 2 address.
- rs1_addr  out  ADDR_W  to register file; equals id_rs1 (combinational).
- rs2_addr  out  ADDR_W  to register file; equals id_rs2 (combinational).
- rs1_rdata  in  DATA_W  register-file read data 1.
- rs2_rdata  in  DATA_W  register-file read data 2.
- wb_en  in  1  writeback valid.
- wb_addr  in  ADDR_W  writeback register.
- wb_data  in  DATA_W  writeback data.
- rd_en  out  1  to register file; equals wb_en.
- rdaddr  out  ADDR_W  equals wb_addr.
- rd_wdata  out  DATA_W  equals wb_data.
- ex_valid  out  1  operands valid to execute.
- ex_ready  in  1  execute consumes.
- ex_opcode  out  OP_W  registered opcode.
- ex_rd  out  ADDR_W  registered rd.
- ex_rd_we  out  1  registered rd_we.
- ex_rs1_data  out  DATA_W  registered operand 1.
- ex_rs2_data  out  DATA_W  registered operand 2.

Behaviour:
- Reset (rst_n=0 at posedge): ex_valid=0; ex_opcode, ex_rd, ex_rd_we, ex_rs1_data, ex_rs2_data = 0; scoreboard pend[] = all 0. Reset overrides any in-flight accept or writeback that cycle.
- Bypass, per source x:
  - src_x = wb_data if wb_en && wb_addr==id_rsx && id_rsx!=0.
  - Otherwise src_x = 0 if id_rsx==0.
  - Otherwise src_x = rsx_rdata.
- Register 0 always reads 0, even if wb_en writes address 0.
- Hazard, per source x: raw_x = id_rsx!=0 && pend[id_rsx] && !(wb_en && wb_addr==id_rsx).
- WAW hazard: waw = id_rd_we && id_rd!=0 && pend[id_rd] && !(wb_en && wb_addr==id_rd).
- hazard = raw_1 | raw_2 | waw.
- id_ready = (!ex_valid || ex_ready) && !hazard. It is combinational and does not depend on id_valid.
- accept = id_valid && id_ready.
- On accept: the ex_* registers load opcode, rd, rd_we, src_1, src_2; ex_valid=1. Latency is 1 cycle from accept to ex_valid.
- When ex_valid && ex_ready && !accept: ex_valid=0. ex_* data holds its last value.
- When !ex_ready && ex_valid: all ex_* outputs hold stable.
- Scoreboard, per register r != 0, evaluated each cycle:
  - set_r = accept && id_rd_we && id_rd==r.
  - clr_r = wb_en && wb_addr==r.
  - pend[r] next = set_r ? 1 : (clr_r ? 0 : pend[r]).
  - Simultaneous set and clear on the same r leaves it set (the new producer wins).
  - pend[0] is always 0.
- Writes to register 0 are never tracked and never cause a hazard.
- Writeback port pass-through is purely combinational, with no added latency.
- Contract: at most one outstanding write per register, guaranteed by the WAW stall. Writeback to a non-pending register is legal and has no scoreboard effect.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> ex_valid=0, all ex_* =0, id_ready=1; id_valid=1 with rs1=3 (reg3=0x1234), rs2=0 -> next cycle ex_valid=1, ex_rs1_data=0x1234, ex_rs2_data=0.
- Same-cycle bypass: reg5=0x00AA; wb_en=1, wb_addr=5, wb_data=0x5555 while issuing rs1=5 -> ex_rs1_data=0x5555. wb to addr 0 with rs2=0 -> ex_rs2_data=0.
- RAW stall: issue rd=7, rd_we=1; next instruction rs1=7 -> id_ready=0 until writeback. wb_en=1, wb_addr=7, wb_data=0xBEEF in the stall cycle -> id_ready=1 that cycle, ex_rs1_data=0xBEEF; pend[7]=0 afterwards.
- WAW and set/clear collision: rd=2 pending; a new rd=2 issue stalls. Issue again on the cycle wb_addr=2 -> accepted, pend[2]=1 afterwards.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> id_ready=0, ex_* unchanged. ex_ready=1 with id_valid=1 -> back-to-back transfer, ex_valid stays 1.
- Reset mid-operation: pend[4]=1, ex_valid=1, rst_n=0 one cycle -> ex_valid=0, pend cleared; then rs1=4 issues without stall.
